// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets, STATUS bit layout and default base for mmio_responder | rev 1.0
`default_nettype none

package mmio_pkg;

  localparam logic [17:0] MMIO_BASE_DEFAULT = 18'h3FFFF;

  localparam logic [2:0] MMIO_LED    = 3'd0;
  localparam logic [2:0] MMIO_CNT    = 3'd1;
  localparam logic [2:0] MMIO_CMP    = 3'd2;
  localparam logic [2:0] MMIO_STATUS = 3'd3;
  localparam logic [2:0] MMIO_TXDATA = 3'd4;

  localparam int ST_IRQ     = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  function automatic logic [31:0] pack_status(input logic irq, input logic full,
                                              input logic empty, input logic ovf,
                                              input logic [4:0] count);
    return {23'b0, count, ovf, empty, full, irq};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular buffer with combinational head; a push into a full
// buffer is accepted only when a pop frees a slot in the same cycle | rev 1.0
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mmio_responder.sv
// mmio_responder: data-bus MMIO slave with LED, cycle counter/compare irq, STATUS and a
// TX FIFO; read data is registered to line up with SRAM q latency | rev 1.0
`default_nettype none

module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [17:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] addr_in,
  input  logic [31:0] data_in,
  input  logic        mem_wren,
  output logic [31:0] rdata,
  output logic        hit_q,
  output logic [31:0] led,
  output logic        irq,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          hit;
  logic [2:0]    off;
  logic          wr;
  logic [31:0]   cnt;
  logic [31:0]   cmp;
  logic          ovf;
  logic [31:0]   rd_mux;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          irq_set;
  logic          irq_clr;
  logic          ovf_set;
  logic          ovf_clr;
  logic          unused_addr;

  // Address bits [11:3] are don't-care, so the eight registers alias across the page.
  assign hit         = (addr_in[29:12] == MMIO_BASE);
  assign off         = addr_in[2:0];
  assign wr          = hit & mem_wren;
  assign unused_addr = ^addr_in[11:3];

  assign push     = wr & (off == MMIO_TXDATA);
  assign pop      = tx_valid & tx_ready;
  assign tx_valid = ~fifo_empty;

  assign irq_set = (cnt == cmp);
  assign irq_clr = wr & (off == MMIO_STATUS) & data_in[ST_IRQ];
  assign ovf_set = push & fifo_full & ~pop;
  assign ovf_clr = wr & (off == MMIO_STATUS) & data_in[ST_OVF];

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (data_in),
    .pop       (pop),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    rd_mux = '0;
    if (hit) begin
      case (off)
        MMIO_LED:    rd_mux = led;
        MMIO_CNT:    rd_mux = cnt;
        MMIO_CMP:    rd_mux = cmp;
        MMIO_STATUS: rd_mux = pack_status(irq, fifo_full, fifo_empty, ovf, 5'(fifo_count));
        default:     rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
      hit_q <= 1'b0;
      led   <= '0;
      cnt   <= '0;
      cmp   <= 32'hFFFF_FFFF;
      irq   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      rdata <= rd_mux;
      hit_q <= hit;
      if (wr && off == MMIO_LED) led <= data_in;
      if (wr && off == MMIO_CMP) cmp <= data_in;
      cnt <= (wr && off == MMIO_CNT) ? 32'd0 : cnt + 32'd1;
      // A new event outranks a software clear arriving in the same cycle.
      if (irq_set)      irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder on the memory stage's data bus: the slave end of the word-addressed access the stage issues. Decodes one 4 KiB-word region outside SRAM, serves a LED register, a free-running cycle counter with compare interrupt, a status register and a TX FIFO drained by an external valid/ready consumer. Read data returns one clock after the request, matching SRAM `q` latency, so the stage muxes `rdata` against SRAM output using the registered `hit_q`.

## Interface
- `MMIO_BASE`, 18'h3FFFF, value of `addr_in[29:12]` selecting this block
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, 2..16
- `clk`  in  1  pipeline clock
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `addr_in`  in  30  word address from memory stage
- `data_in`  in  32  store data
- `mem_wren`  in  1  store strobe, qualified by region hit
- `rdata`  out  32  registered read data for previous-cycle address
- `hit_q`  out  1  previous-cycle address hit this region
- `led`  out  32  LED register contents
- `irq`  out  1  sticky compare interrupt
- `tx_data`  out  32  FIFO head
- `tx_valid`  out  1  FIFO non-empty
- `tx_ready`  in  1  consumer accepts head when `tx_valid & tx_ready`

## Operation
- `hit = (addr_in[29:12] == MMIO_BASE)`; `off = addr_in[2:0]`; `addr_in[11:3]` ignored (aliases).
- off 0 LED: RW.
- off 1 CNT: increments every clock, wraps 0xFFFFFFFF->0; any write clears it (value 0 next cycle, increment suppressed that cycle).
- off 2 CMP: RW. When CNT == CMP, `irq` sets next clock.
- off 3 STATUS (read): bit0 irq, bit1 full, bit2 empty, bit3 overflow, bits[8:4] count, others 0. Write: bit0=1 clears irq, bit3=1 clears overflow; other bits ignored.
- off 4 TXDATA: write pushes `data_in`; read returns 0, no pop.
- off 5..7: reads 0, writes ignored.
- Writes occur only when `hit & mem_wren`.
- FIFO: circular buffer, wrap-around pointers, count 0..FIFO_DEPTH. Push when full: data dropped, overflow set. Pop when `tx_valid & tx_ready`.
- Push and pop same cycle: both performed, count unchanged, including when full (no overflow). Push to empty: `tx_valid` rises next clock, `tx_data` = pushed word.
- irq set and clear same cycle: set wins. Overflow set and clear same cycle: set wins.

## Timing
- Reset values: `rdata`=0, `hit_q`=0, `led`=0, CNT=0, CMP=0xFFFFFFFF, `irq`=0, overflow=0, FIFO empty, `tx_valid`=0, `tx_data`=0.
- Read latency 1: `rdata`/`hit_q` register values sampled at edge N with address of cycle N; visible in cycle N+1. `rdata`=0 when not hit.
- Read-during-write to same register: `rdata` returns pre-write value.
- CNT read returns value present at sampling edge.
- `tx_data` is combinational from FIFO head storage; no bubble between back-to-back pops.
- Reset asserted mid-operation: all state returns to reset values asynchronously; FIFO contents discarded.

## Structure
- Package `mmio_pkg`: offset constants (`MMIO_LED`..`MMIO_TXDATA`), status bit positions, default `MMIO_BASE`.
- One sub-module `sync_fifo` (parameter WIDTH, DEPTH; push/pop/full/empty/count/overflow-free), reusable elsewhere; overflow flag lives in the responder.
- Register file and counter/compare in `mmio_responder`.

## Test plan
- Reset: assert `rst` mid-run with FIFO holding 3 words -> all outputs at reset values, `tx_valid`=0, STATUS read = 0x004.
- Write LED 0xDEADBEEF at MMIO_BASE:0 -> `led`=0xDEADBEEF next cycle; read -> `rdata`=0xDEADBEEF, `hit_q`=1 one cycle later; SRAM-range address -> `hit_q`=0, `rdata`=0.
- Write CMP=10, write CNT (clear) -> `irq` rises exactly 11 clocks after the clear write edge; STATUS write 0x1 -> `irq`=0; CMP=CNT while clearing -> `irq` stays 1.
- Push 9 words with `tx_ready`=0 -> STATUS = full, overflow, count 8; 9th word lost; drain with `tx_ready`=1 -> 8 words in order, one per clock, then `tx_valid`=0.
- FIFO full, simultaneous push and pop -> count stays 8, overflow unchanged, pushed word emerges last.
- Preload CNT near wrap via CMP=0 check: run 2^32 cycles (force CNT=0xFFFFFFFE) -> CNT reads 0xFFFFFFFF, then 0, `irq` sets on 0.
